// File: rtl/cpu_multicycle_param.sv
// Multi-cycle CPU: four registers, unified synchronous-read RAM, valid/ready IN/OUT ports.
// The program is written through prog_* while run=0 and the FSM sits in S_FETCH.
//  state    | meaning
//  S_FETCH  | issue RAM read at pc when run=1, otherwise accept program writes
//  S_DECODE | capture RAM read data into ir
//  S_EXEC   | ALU/MOV/jump complete here; LD/ST/IN/OUT/HALT dispatch
//  S_MEM    | ST writes RAM, LD writes rd from the read issued in S_EXEC
//  S_IN     | wait for in_valid, then rd <= in_data
//  S_OUT    | hold out_data/out_valid until out_ready
//  S_HALT   | stopped until reset
module cpu_multicycle_param #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic            prog_we,
    input  logic [AW-1:0]   prog_addr,
    input  logic [DW+5:0]   prog_wdata,
    input  logic [DW-1:0]   in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [DW-1:0]   out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            halted,
    output logic [AW-1:0]   pc,
    output logic [DW+5:0]   ir,
    output logic [2:0]      flags,
    output logic [4*DW-1:0] regs_dbg
);

    localparam int IW    = DW + 6;
    localparam int DEPTH = 1 << AW;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_IN,
        S_OUT,
        S_HALT
    } state_e;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_ADDI = 4'd5,
        OP_LD   = 4'd6,
        OP_ST   = 4'd7,
        OP_JMP  = 4'd8,
        OP_JZ   = 4'd9,
        OP_JC   = 4'd10,
        OP_JN   = 4'd11,
        OP_IN   = 4'd12,
        OP_OUT  = 4'd13,
        OP_MOV  = 4'd14,
        OP_HALT = 4'd15
    } op_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d, pc_inc;
    logic [IW-1:0]   ir_q;
    logic [DW-1:0]   regs_q [4];
    logic [2:0]      flags_q;
    logic [DW-1:0]   out_data_q;

    logic [IW-1:0]   mem [DEPTH];
    logic [IW-1:0]   mem_rdata;
    logic            mem_re, mem_we;
    logic [AW-1:0]   mem_ra, mem_wa;
    logic [IW-1:0]   mem_wd;

    op_e             op;
    logic [1:0]      rd_sel, rb_sel;
    logic [DW-1:0]   f_imm, rd_val, rb_val;
    logic [AW-1:0]   j_addr;

    logic [DW:0]     alu_wide;
    logic [DW-1:0]   alu_res;
    logic            alu_cf;
    logic [2:0]      alu_flags;
    logic            jump_taken;

    logic            ir_load, reg_we, flag_we, out_load;
    logic [DW-1:0]   reg_wd;

    assign op     = op_e'(ir_q[IW-1:IW-4]);
    assign rd_sel = ir_q[IW-5:IW-6];
    assign f_imm  = ir_q[DW-1:0];
    assign rb_sel = f_imm[DW-1:DW-2];
    assign j_addr = f_imm[AW-1:0];
    assign rd_val = regs_q[rd_sel];
    assign rb_val = regs_q[rb_sel];
    assign pc_inc = pc_q + AW'(1);

    always_comb begin
        alu_wide = '0;
        alu_cf   = 1'b0;
        case (op)
            OP_ADD:  alu_wide = {1'b0, rd_val} + {1'b0, rb_val};
            OP_SUB:  alu_wide = {1'b0, rd_val} - {1'b0, rb_val};
            OP_AND:  alu_wide = {1'b0, rd_val & rb_val};
            OP_OR:   alu_wide = {1'b0, rd_val | rb_val};
            OP_ADDI: alu_wide = {1'b0, rd_val} + {1'b0, f_imm};
            default: alu_wide = '0;
        endcase
        alu_res = alu_wide[DW-1:0];
        if (op == OP_ADD || op == OP_ADDI) begin
            alu_cf = alu_wide[DW];
        end else if (op == OP_SUB) begin
            alu_cf = (rd_val < rb_val);
        end
        alu_flags = {alu_cf, alu_res[DW-1], (alu_res == '0)};
    end

    // Conditional jumps see the flags left by the most recent ALU instruction.
    always_comb begin
        jump_taken = 1'b0;
        case (op)
            OP_JMP:  jump_taken = 1'b1;
            OP_JZ:   jump_taken = flags_q[0];
            OP_JC:   jump_taken = flags_q[2];
            OP_JN:   jump_taken = flags_q[1];
            default: jump_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_load  = 1'b0;
        reg_we   = 1'b0;
        reg_wd   = alu_res;
        flag_we  = 1'b0;
        out_load = 1'b0;
        mem_re   = 1'b0;
        mem_ra   = pc_q;
        mem_we   = 1'b0;
        mem_wa   = j_addr;
        mem_wd   = {{(IW-DW){1'b0}}, rd_val};

        case (state_q)
            S_FETCH: begin
                if (run) begin
                    mem_re  = 1'b1;
                    state_d = S_DECODE;
                end else if (prog_we) begin
                    mem_we = 1'b1;
                    mem_wa = prog_addr;
                    mem_wd = prog_wdata;
                end
            end

            S_DECODE: begin
                ir_load = 1'b1;
                state_d = S_EXEC;
            end

            S_EXEC: begin
                state_d = S_FETCH;
                case (op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
                        reg_we  = 1'b1;
                        flag_we = 1'b1;
                        pc_d    = pc_inc;
                    end
                    OP_MOV: begin
                        reg_we = 1'b1;
                        reg_wd = f_imm;
                        pc_d   = pc_inc;
                    end
                    OP_JMP, OP_JZ, OP_JC, OP_JN: begin
                        pc_d = jump_taken ? j_addr : pc_inc;
                    end
                    OP_LD: begin
                        mem_re  = 1'b1;
                        mem_ra  = j_addr;
                        state_d = S_MEM;
                    end
                    OP_ST:   state_d = S_MEM;
                    OP_IN:   state_d = S_IN;
                    OP_OUT: begin
                        out_load = 1'b1;
                        state_d  = S_OUT;
                    end
                    OP_HALT: state_d = S_HALT;
                    default: pc_d = pc_inc;
                endcase
            end

            S_MEM: begin
                if (op == OP_ST) begin
                    mem_we = 1'b1;
                end else begin
                    reg_we = 1'b1;
                    reg_wd = mem_rdata[DW-1:0];
                end
                pc_d    = pc_inc;
                state_d = S_FETCH;
            end

            S_IN: begin
                if (in_valid) begin
                    reg_we  = 1'b1;
                    reg_wd  = in_data;
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end
            end

            S_OUT: begin
                if (out_ready) begin
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end
            end

            S_HALT:  state_d = S_HALT;

            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_FETCH;
            pc_q       <= '0;
            ir_q       <= '0;
            flags_q    <= '0;
            out_data_q <= '0;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (ir_load) begin
                ir_q <= mem_rdata;
            end
            if (reg_we) begin
                regs_q[rd_sel] <= reg_wd;
            end
            if (flag_we) begin
                flags_q <= alu_flags;
            end
            if (out_load) begin
                out_data_q <= rd_val;
            end
        end
    end

    // RAM keeps its contents across reset; reads return data one cycle later.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
        if (mem_re) begin
            mem_rdata <= mem[mem_ra];
        end
    end

    assign in_ready  = (state_q == S_IN);
    assign out_valid = (state_q == S_OUT);
    assign halted    = (state_q == S_HALT);
    assign out_data  = out_data_q;
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign flags     = flags_q;
    assign regs_dbg  = {regs_q[3], regs_q[2], regs_q[1], regs_q[0]};

endmodule
